// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the instruction/data memory responder.
//   ADDR_W / DATA_W : word-address and data widths of both request ports.
//   NOP_INSTR       : word returned to fetch when no valid instruction exists.
//   mem_port_t      : which requester an access or response belongs to.
//   resp_t          : one entry of the read-response pipeline.
package mem_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'hf000_0000;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } mem_port_t;

    typedef struct packed {
        logic              valid;
        mem_port_t         port;
        logic              is_write;
        logic              err;
        logic [DATA_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-grant arbiter between the fetch and data requesters.
// Data normally wins; after STARVE_MAX consecutive cycles of fetch being
// refused, fetch wins one arbitration.
//   clk, rst_async : clock, asynchronous active-high reset
//   f_req, d_req   : requests
//   f_gnt, d_gnt   : grants (combinational, at most one high)
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_async,
    input  logic f_req,
    input  logic d_req,
    output logic f_gnt,
    output logic d_gnt
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] SAT = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    assign f_gnt = f_req && (!d_req || starve_cnt == SAT);
    assign d_gnt = d_req && !f_gnt;

    // Counts refused fetch cycles; any fetch grant or a dropped fetch
    // request restarts the count.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            starve_cnt <= '0;
        else if (!f_req || f_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != SAT)
            starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: single-port word memory serving the instruction fetch port
// and a data read/write port, one access per cycle.
//   clk, rst_async            : clock, asynchronous active-high reset
//   f_req/f_addr -> f_gnt     : fetch request and combinational grant
//   f_rvalid/f_rdata/f_err    : fetch response (err qualified by f_rvalid)
//   d_req/d_we/d_addr/d_wdata : data request; d_gnt combinational grant
//   d_rvalid/d_rdata          : data read response
//   d_err                     : data access out of range (reads and writes)
// Responses appear LATENCY edges after the grant edge; rdata holds between
// responses of its own port.
module imem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0]     acc_addr;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_oor;
    resp_t                 new_ent;
    resp_t [LATENCY-1:0]   resp_pipe;
    resp_t [LATENCY-1:0]   pipe_in;
    resp_t                 last_in;
    resp_t                 out_ent;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk       (clk),
        .rst_async (rst_async),
        .f_req     (f_req),
        .d_req     (d_req),
        .f_gnt     (f_gnt),
        .d_gnt     (d_gnt)
    );

    assign acc_addr = d_gnt ? d_addr : f_addr;
    assign acc_idx  = acc_addr[DEPTH_LOG2-1:0];
    // Full-width compare: high address bits never alias onto the array.
    assign acc_oor  = (acc_addr >> DEPTH_LOG2) != '0;

    always_comb begin
        new_ent          = '0;
        new_ent.valid    = f_gnt | d_gnt;
        new_ent.port     = d_gnt ? PORT_DATA : PORT_FETCH;
        new_ent.is_write = d_gnt && d_we;
        new_ent.err      = acc_oor;
        if (acc_oor)
            new_ent.data = d_gnt ? '0 : NOP_INSTR;
        else
            new_ent.data = mem[acc_idx];
    end

    // Write lands at the grant edge, so a read granted next cycle sees it.
    always_ff @(posedge clk) begin
        if (d_gnt && d_we && !acc_oor)
            mem[acc_idx] <= d_wdata;
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign pipe_in = new_ent;
        end else begin : g_latn
            assign pipe_in = {resp_pipe[LATENCY-2:0], new_ent};
        end
    endgenerate

    assign last_in = pipe_in[LATENCY-1];
    assign out_ent = resp_pipe[LATENCY-1];

    // rdata registers load from the entry entering the final stage, so they
    // change on the same edge the matching rvalid rises.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            resp_pipe <= '0;
            f_rdata   <= NOP_INSTR;
            d_rdata   <= '0;
        end else begin
            resp_pipe <= pipe_in;
            if (last_in.valid && !last_in.is_write) begin
                if (last_in.port == PORT_FETCH)
                    f_rdata <= last_in.data;
                else
                    d_rdata <= last_in.data;
            end
        end
    end

    assign f_rvalid = out_ent.valid && out_ent.port == PORT_FETCH;
    assign f_err    = f_rvalid && out_ent.err;
    assign d_rvalid = out_ent.valid && out_ent.port == PORT_DATA && !out_ent.is_write;
    assign d_err    = out_ent.valid && out_ent.port == PORT_DATA && out_ent.err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed stimulus for imem_responder,
// checked every cycle against a queue-based reference model, plus literal
// expectations for the documented scenarios.
module tb_imem_responder;
    import mem_pkg::*;

    localparam int DL = 12;
    localparam int L  = 2;
    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        rst_async = 1'b1;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [19:0] f_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
    logic [31:0] f_rdata, d_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_LOG2(DL), .LATENCY(L), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_async(rst_async),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        bit          rd;
    } exp_t;

    exp_t        fq[$];
    exp_t        dq[$];
    logic [31:0] mm[int];
    int          m_starve = 0;
    logic [31:0] m_f = 32'hf000_0000;
    logic [31:0] m_d = 32'h0;

    function automatic logic [31:0] mrd(input logic [19:0] a);
        if (mm.exists(int'(a))) return mm[int'(a)];
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        bit   e_fv, e_fe, e_dv, e_de, fw, oor;
        exp_t e;
        if (rst_async) begin
            fq.delete();
            dq.delete();
            m_starve = 0;
            m_f      = 32'hf000_0000;
            m_d      = 32'h0;
            chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("rst_f_err",    32'(f_err),    32'd0);
            chk("rst_d_err",    32'(d_err),    32'd0);
            chk("rst_f_rdata",  f_rdata,       32'hf000_0000);
            chk("rst_d_rdata",  d_rdata,       32'h0);
        end else begin
            // responses due this cycle
            e_fv = 0; e_fe = 0; e_dv = 0; e_de = 0;
            if (fq.size() > 0 && fq[0].due == cyc) begin
                e_fv = 1;
                e_fe = fq[0].err;
                m_f  = fq[0].data;
                void'(fq.pop_front());
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                e_de = dq[0].err;
                if (dq[0].rd) begin
                    e_dv = 1;
                    m_d  = dq[0].data;
                end
                void'(dq.pop_front());
            end
            chk("f_rvalid", 32'(f_rvalid), 32'(e_fv));
            chk("f_err",    32'(f_err),    32'(e_fe));
            chk("f_rdata",  f_rdata,       m_f);
            chk("d_rvalid", 32'(d_rvalid), 32'(e_dv));
            chk("d_err",    32'(d_err),    32'(e_de));
            chk("d_rdata",  d_rdata,       m_d);

            // fetch wins when data is idle or fetch has been refused SM times running
            fw = f_req && (!d_req || m_starve >= SM);
            chk("f_gnt", 32'(f_gnt), 32'(fw));
            chk("d_gnt", 32'(d_gnt), 32'(d_req && !fw));

            if (fw) begin
                oor    = f_addr >= 20'(1 << DL);
                e.due  = cyc + L;
                e.err  = oor;
                e.rd   = 1;
                e.data = oor ? NOP_INSTR : mrd(f_addr);
                fq.push_back(e);
            end else if (d_req) begin
                oor   = d_addr >= 20'(1 << DL);
                e.due = cyc + L;
                e.err = oor;
                e.rd  = !d_we;
                e.data = oor ? 32'h0 : mrd(d_addr);
                if (d_we && !oor) mm[int'(d_addr)] = d_wdata;
                dq.push_back(e);
            end

            if (f_req && !fw) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            else              m_starve = 0;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req = 0;
        d_req = 0;
        d_we  = 0;
    endtask

    function automatic logic [19:0] raddr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return 20'($urandom_range(0, 63));
        if (r == 7) return 20'h00fff;
        if (r == 8) return 20'h01000;
        return 20'($urandom_range(32'h01001, 32'hfffff));
    endfunction

    function automatic logic [31:0] init_val(input int a);
        return 32'ha500_0000 | 32'(a);
    endfunction

    initial begin
        logic [31:0] ev;
        idle();
        rst_async = 1;
        repeat (3) step();
        chk("reset_f_rdata",  f_rdata,       32'hf000_0000);
        chk("reset_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("reset_d_rvalid", 32'(d_rvalid), 32'd0);
        rst_async = 0;
        step();
        chk("release_f_rdata",  f_rdata,       32'hf000_0000);
        chk("release_f_rvalid", 32'(f_rvalid), 32'd0);

        // preload 0..63 and the top word
        for (int i = 0; i <= 64; i++) begin
            d_req   = 1;
            d_we    = 1;
            d_addr  = (i == 64) ? 20'h00fff : 20'(i);
            d_wdata = init_val(int'(d_addr));
            step();
        end
        idle();
        step();

        // write then fetch the same word
        d_req = 1; d_we = 1; d_addr = 20'd5; d_wdata = 32'h1234_5678;
        step();
        idle();
        f_req = 1; f_addr = 20'd5;
        #1;
        chk("wf_gnt", 32'(f_gnt), 32'd1);
        step();
        f_req = 0;
        chk("wf_early_rvalid", 32'(f_rvalid), 32'd0);
        step();
        chk("wf_rvalid", 32'(f_rvalid), 32'd1);
        chk("wf_rdata",  f_rdata,       32'h1234_5678);
        chk("wf_err",    32'(f_err),    32'd0);
        step();

        // starvation guard: 3 data grants then 1 fetch grant, repeating
        f_req = 1; f_addr = 20'd2;
        d_req = 1; d_we = 0; d_addr = 20'd1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("starve_f_gnt", 32'(f_gnt), 32'(i % 4 == 3));
            chk("starve_d_gnt", 32'(d_gnt), 32'(i % 4 != 3));
            step();
        end
        idle();
        repeat (3) step();

        // out of range fetch and write
        f_req = 1; f_addr = 20'h01000;
        step();
        idle();
        step();
        chk("oor_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("oor_f_rdata",  f_rdata,       32'hf000_0000);
        chk("oor_f_err",    32'(f_err),    32'd1);
        d_req = 1; d_we = 1; d_addr = 20'h01000; d_wdata = 32'hdead_beef;
        step();
        idle();
        step();
        chk("oor_d_err",    32'(d_err),    32'd1);
        chk("oor_d_rvalid", 32'(d_rvalid), 32'd0);
        d_req = 1; d_we = 0; d_addr = 20'd0;
        step();
        idle();
        step();
        chk("addr0_rvalid", 32'(d_rvalid), 32'd1);
        chk("addr0_rdata",  d_rdata,       32'ha500_0000);
        step();

        // back-to-back fetch stream 0..7
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                f_req  = 1;
                f_addr = 20'(j);
            end else begin
                idle();
            end
            if (j >= 2) begin
                ev = (j - 2 == 5) ? 32'h1234_5678 : (32'ha500_0000 | 32'(j - 2));
                chk("stream_rvalid", 32'(f_rvalid), 32'd1);
                chk("stream_rdata",  f_rdata,       ev);
            end
            step();
        end
        chk("stream_end_rvalid", 32'(f_rvalid), 32'd0);

        // reset pulse one cycle after a read grant
        f_req = 1; f_addr = 20'd3;
        step();
        idle();
        rst_async = 1;
        step();
        rst_async = 0;
        for (int j = 0; j < 4; j++) begin
            chk("midrst_rvalid", 32'(f_rvalid), 32'd0);
            chk("midrst_rdata",  f_rdata,       32'hf000_0000);
            step();
        end

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle();
                rst_async = 1;
                step();
                rst_async = 0;
            end else begin
                f_req   = 1'($urandom_range(0, 1));
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                f_addr  = raddr();
                d_addr  = raddr();
                d_wdata = $urandom;
                step();
            end
        end
        idle();
        repeat (L + 3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the instruction fetch interface, plus a data read/write port sharing one single-port word array.
- Accepts one access per cycle and arbitrates fetch against data, with data having priority and a starvation guard protecting fetch.
- Returns read data through a fixed-latency pipeline with a valid strobe.
- Sits between the fetch unit / load-store path and on-chip storage; also the path by which the bench or boot loader writes program images.

Parameters:
- DEPTH_LOG2, 12: array holds 2**DEPTH_LOG2 32-bit words.
- LATENCY, 2: clock edges from grant to read response; legal range 1..4.
- STARVE_MAX, 3: consecutive denied fetch cycles after which fetch wins one arbitration.

Ports:
- clk  input  1  clock.
- rst_async  input  1  reset, asynchronous, active-high.
- f_req  input  1  fetch read request.
- f_addr  input  20  fetch word address.
- f_gnt  output  1  fetch request accepted this cycle (combinational).
- f_rvalid  output  1  fetch response valid, one-cycle pulse.
- f_rdata  output  32  fetch read data.
- f_err  output  1  fetch response was out of range; qualified by f_rvalid.
- d_req  input  1  data request.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  20  data word address.
- d_wdata  input  32  write data.
- d_gnt  output  1  data request accepted this cycle (combinational).
- d_rvalid  output  1  data read response valid, one-cycle pulse.
- d_rdata  output  32  data read data.
- d_err  output  1  data access out of range; pulses for reads and writes.

Behaviour:
- **Reset values:**
  - f_rvalid = d_rvalid = f_err = d_err = 0.
  - f_rdata = 32'hf000_0000 (NOP); d_rdata = 0.
  - Starve counter = 0; all pipeline valids cleared.
  - Array contents are not reset.
- **Arbitration** (combinational, each cycle):
  - Default: d_req wins.
  - If f_req and starve counter == STARVE_MAX, fetch wins and d_gnt = 0.
  - At most one gnt is high.
  - gnt = 0 whenever the corresponding req = 0.
- **Starve counter:**
  - Increments on each edge where f_req = 1 and f_gnt = 0, saturating at STARVE_MAX.
  - Clears on f_gnt, or when f_req = 0.
- **Access:** a granted access is performed at the next rising edge (edge k).
- **Write:**
  - Array[d_addr] updated at edge k.
  - No d_rvalid.
  - If out of range, the write is dropped and d_err pulses in the cycle after edge k+LATENCY-1.
- **Read:**
  - Array is read at edge k and the result enters the pipeline.
  - The port's rvalid is high for exactly the one cycle following edge k+LATENCY-1.
  - rdata updates at that same edge and holds until the next response for that port.
- **Latency:** LATENCY=1 → response visible in the cycle immediately after the grant edge. Back-to-back grants give back-to-back responses, in order.
- **Out of range:** address >= 2**DEPTH_LOG2.
  - Read data = 0 for the data port, 32'hf000_0000 for the fetch port.
  - err = 1 with rvalid.
  - No wrap-around.
- **Read-after-write:** a read granted the cycle after a write to the same address returns the new data.
- **Simultaneous requests:** both requesters hold req until they see gnt. The losing request must be re-presented; nothing is queued.
- **Reset mid-operation:** in-flight pipeline entries are discarded, and no rvalid is produced for them after reset deasserts.
- **Address width:** full 20-bit compare for the range check; low DEPTH_LOG2 bits index the array.

Decomposition:
- **Package mem_pkg:**
  - ADDR_W = 20, DATA_W = 32.
  - NOP_INSTR = 32'hf000_0000.
  - typedef enum {PORT_FETCH, PORT_DATA} mem_port_t.
  - Struct resp_t {valid, mem_port_t port, is_write, err, data}.
- **Sub-module mem_arbiter:** fixed priority with starvation counter, producing f_gnt / d_gnt.
- **Top-level (imem_responder):** the array and a LATENCY-deep resp_t shift register.

Test Plan:
- **Reset values:** assert rst_async → f_rdata = 32'hf000_0000, both rvalids 0. Release → outputs unchanged until the first response.
- **Write then fetch:**
  - Stimulus: data writes 32'h1234_5678 to addr 5, then fetch reads addr 5 (LATENCY=2).
  - Required: f_rvalid = 1 exactly 2 edges after the fetch grant, f_rdata = 32'h1234_5678, f_err = 0.
- **Starvation guard:**
  - Stimulus: d_req and f_req both held high continuously (STARVE_MAX=3).
  - Required: d_gnt for 3 cycles, then f_gnt for 1 cycle; pattern repeats 3:1.
- **Out of range:**
  - Stimulus: fetch addr 20'h01000 (DEPTH_LOG2=12), and a data write to the same address.
  - Required: fetch responds f_rdata = 32'hf000_0000 with f_err = 1; the write gives d_err pulse, and array addr 0 is unchanged.
- **Back-to-back streaming:** 8 consecutive fetches, addr 0..7 → 8 consecutive f_rvalid cycles with data in address order.
- **Reset mid-flight:** rst_async pulsed one cycle after a read grant → no f_rvalid afterward; f_rdata = 32'hf000_0000.
